la32_hazard_scoreboard: RTL

- Parametrised hazard-detection and forwarding controller for the LA32 in-order pipeline.
- Sits beside the ID stage and tracks destination registers in flight in stages EX..WB.
- Decides each cycle whether the ID instruction issues, stalls or is flushed.
- Produces registered forwarding selects that travel with the instruction into EX.
- Generalises the fixed 2-port load-use/branch logic to any pipeline depth, read-port count and load latency. Adds a variable-latency memory freeze and performance counters.

---
 rtl/la32_pipe_pkg.sv | 19 +
 rtl/la32_sb_match.sv | 30 +++
 rtl/la32_hazard_scoreboard.sv | 110 +++++++++++
 3 files changed

// File: rtl/la32_pipe_pkg.sv
// Shared types and helpers for the LA32 hazard scoreboard: entry layout,
// the "read from register file" select value and producer data availability.
package la32_pipe_pkg;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } sb_entry_t;

  localparam int FWD_RF = 0;

  // Number of stages after EX before a producer's result can be forwarded.
  function automatic int avail(input logic ld, input int ld_lat);
    return ld ? (1 + ld_lat) : 1;
  endfunction

endpackage

// File: rtl/la32_sb_match.sv
// Youngest-match priority encoder for one ID read port over the in-flight
// scoreboard entries; yields the hazard flag and next-cycle forwarding select.
module la32_sb_match
  import la32_pipe_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int LD_LAT = 1,
  parameter int SW     = $clog2(DEPTH)
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic                  en,
  input  logic [4:0]            rs,
  output logic                  hazard,
  output logic [SW-1:0]         sel
);

  always_comb begin
    hazard = 1'b0;
    sel    = SW'(FWD_RF);
    // Walk oldest to youngest so the lowest matching index wins.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (en && (rs != 5'd0) && entries[k].v && entries[k].we &&
          (entries[k].rd == rs)) begin
        hazard = ((k + 1) < avail(entries[k].ld, LD_LAT));
        sel    = ((k + 1) <= (DEPTH - 1)) ? SW'(k + 1) : SW'(FWD_RF);
      end
    end
  end

endmodule

// File: rtl/la32_hazard_scoreboard.sv
// Hazard detection and forwarding control beside ID: tracks destinations in
// flight EX..WB, decides issue/stall/flush and registers forwarding selects.
module la32_hazard_scoreboard
  import la32_pipe_pkg::*;
#(
  parameter int NRP    = 2,
  parameter int DEPTH  = 3,
  parameter int LD_LAT = 1,
  parameter int SW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              id_valid,
  input  logic [NRP*5-1:0]  id_rs,
  input  logic [NRP-1:0]    id_rs_used,
  input  logic [4:0]        id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              ex_br_taken,
  input  logic              mem_stall,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_clr,
  output logic              idex_clr,
  output logic [NRP*SW-1:0] fwd_sel,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
);

  sb_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [NRP*SW-1:0]     fwd_sel_q, fwd_sel_d;
  logic [31:0]           stall_cnt_q, stall_cnt_d;
  logic [31:0]           flush_cnt_q, flush_cnt_d;
  logic [NRP-1:0]        hazard_vec;
  logic [NRP*SW-1:0]     sel_next;
  logic                  load_use;

  for (genvar p = 0; p < NRP; p++) begin : g_port
    la32_sb_match #(
      .DEPTH  (DEPTH),
      .LD_LAT (LD_LAT),
      .SW     (SW)
    ) u_match (
      .entries (entries_q),
      .en      (id_valid & id_rs_used[p]),
      .rs      (id_rs[p*5 +: 5]),
      .hazard  (hazard_vec[p]),
      .sel     (sel_next[p*SW +: SW])
    );
  end

  assign load_use = id_valid & (|hazard_vec);

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_clr    = 1'b0;
    idex_clr    = 1'b0;
    entries_d   = entries_q;
    fwd_sel_d   = fwd_sel_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (mem_stall) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
    end else begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        entries_d[k] = entries_q[k-1];
      end
      entries_d[0] = '0;
      fwd_sel_d    = '0;
      if (ex_br_taken) begin
        ifid_clr    = 1'b1;
        idex_clr    = 1'b1;
        flush_cnt_d = (flush_cnt_q == 32'hFFFF_FFFF) ? flush_cnt_q : flush_cnt_q + 32'd1;
      end else if (load_use) begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_clr    = 1'b1;
        stall_cnt_d = (stall_cnt_q == 32'hFFFF_FFFF) ? stall_cnt_q : stall_cnt_q + 32'd1;
      end else begin
        // r0 writes are tracked as non-writing so they never forward.
        entries_d[0].v  = id_valid;
        entries_d[0].rd = id_rd;
        entries_d[0].we = id_we & (id_rd != 5'd0);
        entries_d[0].ld = id_is_load;
        fwd_sel_d       = sel_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      entries_q   <= '0;
      fwd_sel_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      entries_q   <= entries_d;
      fwd_sel_q   <= fwd_sel_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fwd_sel   = fwd_sel_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
